inst_fetch: RTL

- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's address and write inputs.
- Captures the registered 32-bit read data and presents instructions with their PCs to decode over a valid/ready handshake.
- Supports branch redirect with flush of in-flight fetches and a fetch-enable gate, and sustains one instruction per cycle.

---
 rtl/inst_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a
// registered-output instruction memory and buffers responses for decode.
module inst_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_write,
    output logic [DATA_W-1:0] imem_datain,
    input  logic [DATA_W-1:0] imem_dataout,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    logic [ADDR_W-1:0]            pc_r, pc_n_s;
    logic                         pend_r, pend_n_s;
    logic [ADDR_W-1:0]            pend_pc_r, pend_pc_n_s;
    logic [1:0]                   count_r, count_n_s;
    logic [1:0][DATA_W-1:0]       buf_inst_r, buf_inst_n_s;
    logic [1:0][ADDR_W-1:0]       buf_pc_r, buf_pc_n_s;

    logic       pop_s;
    logic       push_s;
    logic       issue_s;
    logic [2:0] occ_s;
    logic [1:0] slot_s;

    // Handshake and issue decision; occupancy counts buffered plus in-flight
    always_comb begin
        pop_s   = (count_r != 2'd0) && inst_ready;
        push_s  = pend_r && !redirect;
        occ_s   = {1'b0, count_r} + {2'b00, pend_r};
        issue_s = fetch_en && !redirect &&
                  ((occ_s < 3'd2) || ((occ_s == 3'd2) && pop_s));
        if (pop_s) begin
            slot_s = count_r - 2'd1;
        end else begin
            slot_s = count_r;
        end
    end

    // Next-state for PC, pending fetch and the two-entry response buffer
    always_comb begin
        pc_n_s       = pc_r;
        pend_n_s     = 1'b0;
        pend_pc_n_s  = pend_pc_r;
        count_n_s    = count_r;
        buf_inst_n_s = buf_inst_r;
        buf_pc_n_s   = buf_pc_r;
        if (redirect) begin
            pc_n_s    = redirect_pc;
            count_n_s = 2'd0;
        end else begin
            if (issue_s) begin
                pend_n_s    = 1'b1;
                pend_pc_n_s = pc_r;
                pc_n_s      = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                pend_n_s = 1'b0;
            end
            // Head always lives in entry 0, so a pop shifts entry 1 down
            if (pop_s) begin
                buf_inst_n_s[0] = buf_inst_r[1];
                buf_pc_n_s[0]   = buf_pc_r[1];
            end else begin
                buf_inst_n_s[0] = buf_inst_r[0];
                buf_pc_n_s[0]   = buf_pc_r[0];
            end
            if (push_s) begin
                buf_inst_n_s[slot_s[0]] = imem_dataout;
                buf_pc_n_s[slot_s[0]]   = pend_pc_r;
            end else begin
                buf_inst_n_s[1] = buf_inst_r[1];
            end
            case ({push_s, pop_s})
                2'b10:   count_n_s = count_r + 2'd1;
                2'b01:   count_n_s = count_r - 2'd1;
                default: count_n_s = count_r;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r       <= RESET_PC;
            pend_r     <= 1'b0;
            pend_pc_r  <= {ADDR_W{1'b0}};
            count_r    <= 2'd0;
            buf_inst_r <= {(2*DATA_W){1'b0}};
            buf_pc_r   <= {(2*ADDR_W){1'b0}};
        end else begin
            pc_r       <= pc_n_s;
            pend_r     <= pend_n_s;
            pend_pc_r  <= pend_pc_n_s;
            count_r    <= count_n_s;
            buf_inst_r <= buf_inst_n_s;
            buf_pc_r   <= buf_pc_n_s;
        end
    end

    assign imem_addr   = pc_r;
    assign imem_write  = 1'b0;
    assign imem_datain = {DATA_W{1'b0}};
    assign inst_valid  = (count_r != 2'd0);
    assign inst        = buf_inst_r[0];
    assign inst_pc     = buf_pc_r[0];

endmodule
